sram22_sp_model: RTL and testbench
==================================

// Module: sram22_sp_model
// PURPOSE
//  Parametrised single-port SRAM22 behavioural model for BIST and SoC simulation; successor to fixed-size macros.
//  Generic width/depth/mask granularity, selectable 1- or 2-cycle read latency, valid/ready request port.
//  Hardware clear engine zeroes the array after reset or on request.
//  Sits between the BIST controller / tile adapter and the array; sae_int gives the sense-amp strobe for tracking.
// PARAMETERS
//  DATA_WIDTH      64  word width in bits; must be a multiple of WMASK_WIDTH
//  ADDR_WIDTH      10  address bits; RAM_DEPTH = 1<<ADDR_WIDTH
//  WMASK_WIDTH     2   write-mask lanes; lane k covers bits [k*LANE+:LANE], LANE = DATA_WIDTH/WMASK_WIDTH
//  READ_LATENCY    1   1 or 2 cycles from accepted read to dout_valid; other values are a compile-time error
//  CLEAR_ON_RESET  1   1: run the clear sweep automatically after rstb deasserts
// PORTS
//  clk          in   1             clock, rising edge
//  rstb         in   1             asynchronous active-low reset
//  req_valid    in   1             request present
//  req_ready    out  1             request accepted when req_valid && req_ready
//  we           in   1             1 = write, 0 = read
//  wmask        in   WMASK_WIDTH   per-lane write enable, ignored on reads
//  addr         in   ADDR_WIDTH    word address
//  din          in   DATA_WIDTH    write data
//  dout         out  DATA_WIDTH    read data, valid only while dout_valid = 1
//  dout_valid   out  1             one-cycle pulse per accepted read
//  sae_int      out  1             sense-amp strobe; pulses the cycle after a read is accepted
//  clear_start  in   1             1-cycle pulse, IDLE only: start the clear sweep
//  busy         out  1             clear sweep in progress
// BEHAVIOUR
//  Reset (rstb=0, async): dout=0, dout_valid=0, sae_int=0, pipe valids=0, clr_cnt=0.
//   State forced to CLEAR if CLEAR_ON_RESET, else IDLE. busy=CLEAR_ON_RESET, req_ready=!busy.
//   Array contents are not touched by rstb itself; simulation initial contents are all zero.
//  FSM IDLE/CLEAR:
//   IDLE -> CLEAR on clear_start.
//   CLEAR: each cycle writes 0 to mem[clr_cnt] and increments clr_cnt.
//   CLEAR -> IDLE after the write to RAM_DEPTH-1; clr_cnt wraps to 0. Sweep takes exactly RAM_DEPTH cycles.
//   During CLEAR: busy=1, req_ready=0; clear_start is ignored.
//  req_ready = (state==IDLE); combinational from state only, never from req_valid.
//  Write accept: at the edge, mem[addr] lane k <= din lane k for every wmask[k]=1; other lanes keep their value.
//   A write does not change dout; dout_valid=0.
//  Read accept at edge T: sae_int=1 in cycle T+1.
//   READ_LATENCY=1: dout=mem[addr], dout_valid=1 during T+1.
//   READ_LATENCY=2: same data and dout_valid=1 during T+2.
//  Back-to-back reads stream one per cycle. dout holds its last value when dout_valid=0.
//  Read of an address written in the previous cycle returns the new data. No same-cycle collision: single port.
//  wmask=0 write is a legal no-op that still consumes the request.
//  Reset asserted mid-sweep aborts it; the sweep restarts from address 0 after release if CLEAR_ON_RESET.
//   Addresses already cleared stay cleared. Reset also drops reads in flight: no dout_valid afterwards.
//  Cleared words are 0 in every lane.
// STRUCTURE
//  sram22_pkg: state enum {ST_IDLE, ST_CLEAR}, READ_LATENCY legality check function, LANE width helper.
//  Sub-module sram22_rd_pipe (DATA_WIDTH, READ_LATENCY): valid/data shift stage producing dout/dout_valid.
//  Top holds the array, FSM, clr_cnt and lane-masked write loop.
// TESTING
//  1 CLEAR_ON_RESET=1, DEPTH=1024: release rstb -> busy=1 and req_ready=0 for exactly 1024 cycles, then all reads return 0.
//  2 Write 0xDEADBEEF_CAFEF00D @5 with wmask=2'b01, then read @5 -> dout=0x00000000_CAFEF00D, dout_valid at T+READ_LATENCY.
//  3 Write @7 then read @7 next cycle -> new data.
//    Reads @0..3 back-to-back -> four consecutive dout_valid pulses in order, four sae_int pulses.
//  4 Pulse rstb low at clr_cnt=300 -> busy stays 1, sweep restarts at 0 and takes 1024 cycles. Pulse clear_start mid-sweep -> no effect.
//  5 READ_LATENCY=2, DATA_WIDTH=32, WMASK_WIDTH=4: byte-mask writes per lane and latency check.
//    Assert rstb with a read in flight -> no dout_valid.
//  6 CLEAR_ON_RESET=0: busy=0 after reset. Write @1, clear_start -> busy 1024 cycles, then read @1 = 0.

Source files
------------

// File: rtl/sram22_pkg.sv
// Shared types and elaboration helpers for the SRAM22 single-port model.
package sram22_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } state_e;

   function automatic bit lat_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction

   function automatic int lane_w(input int dw, input int mw);
      return dw / mw;
   endfunction

endpackage

// File: rtl/sram22_sp_model_if.sv
// Request/response bundle between a BIST or tile master and the SRAM22 model.
interface sram22_sp_model_if #(
   parameter int DATA_WIDTH  = 64,
   parameter int ADDR_WIDTH  = 10,
   parameter int WMASK_WIDTH = 2
);
   logic                   req_valid;
   logic                   req_ready;
   logic                   we;
   logic [WMASK_WIDTH-1:0] wmask;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [DATA_WIDTH-1:0]  din;
   logic [DATA_WIDTH-1:0]  dout;
   logic                   dout_valid;
   logic                   sae_int;
   logic                   clear_start;
   logic                   busy;

   modport master (
      output req_valid, we, wmask, addr, din, clear_start,
      input  req_ready, dout, dout_valid, sae_int, busy
   );

   modport slave (
      input  req_valid, we, wmask, addr, din, clear_start,
      output req_ready, dout, dout_valid, sae_int, busy
   );
endinterface

// File: rtl/sram22_rd_pipe.sv
// Read-data stage: 1- or 2-deep valid/data shift producing dout and the sense-amp strobe.
module sram22_rd_pipe #(
   parameter int DATA_WIDTH   = 64,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rstb,
   input  logic                  rd_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   output logic [DATA_WIDTH-1:0] dout_o,
   output logic                  valid_o,
   output logic                  sae_o
);

   logic                  sae_q;
   logic                  vld_q;
   logic [DATA_WIDTH-1:0] dout_q;

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) sae_q <= 1'b0;
      else       sae_q <= rd_i;
   end

   generate
      if (READ_LATENCY == 1) begin : g_l1
         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               vld_q  <= 1'b0;
               dout_q <= '0;
            end else begin
               vld_q <= rd_i;
               if (rd_i) dout_q <= rdata_i;
            end
         end
      end else begin : g_l2
         logic                  s1_vld_q;
         logic [DATA_WIDTH-1:0] s1_dat_q;

         always_ff @(posedge clk or negedge rstb) begin
            if (!rstb) begin
               s1_vld_q <= 1'b0;
               s1_dat_q <= '0;
               vld_q    <= 1'b0;
               dout_q   <= '0;
            end else begin
               s1_vld_q <= rd_i;
               if (rd_i) s1_dat_q <= rdata_i;
               vld_q <= s1_vld_q;
               if (s1_vld_q) dout_q <= s1_dat_q;
            end
         end
      end
   endgenerate

   assign dout_o  = dout_q;
   assign valid_o = vld_q;
   assign sae_o   = sae_q;

endmodule

// File: rtl/sram22_sp_model.sv
// Parametrised single-port SRAM22 behavioural model with clear engine.
module sram22_sp_model
   import sram22_pkg::*;
#(
   parameter int DATA_WIDTH     = 64,
   parameter int ADDR_WIDTH     = 10,
   parameter int WMASK_WIDTH    = 2,
   parameter int READ_LATENCY   = 1,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input logic               clk,
   input logic               rstb,
   sram22_sp_model_if.slave  bus
);

   localparam int     RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam int     LANE      = lane_w(DATA_WIDTH, WMASK_WIDTH);
   localparam state_e RST_ST    = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

   generate
      if (!lat_ok(READ_LATENCY)) begin : g_bad_lat
         $error("sram22_sp_model: READ_LATENCY must be 1 or 2");
      end
      if ((DATA_WIDTH % WMASK_WIDTH) != 0) begin : g_bad_mask
         $error("sram22_sp_model: DATA_WIDTH not a multiple of WMASK_WIDTH");
      end
   endgenerate

   state_e                 state_q, state_d;
   logic [ADDR_WIDTH-1:0]  clr_cnt_q, clr_cnt_d;
   logic                   acc, wr, rd, clr_en;
   logic [DATA_WIDTH-1:0]  mem [RAM_DEPTH];

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.busy      = (state_q == ST_CLEAR);
   assign acc           = bus.req_valid && bus.req_ready;
   assign wr            = acc && bus.we;
   assign rd            = acc && !bus.we;
   assign clr_en        = (state_q == ST_CLEAR);

   always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
         state_q   <= RST_ST;
         clr_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.clear_start) state_d = ST_CLEAR;
         end
         ST_CLEAR: begin
            clr_cnt_d = clr_cnt_q + 1'b1;
            if (clr_cnt_q == {ADDR_WIDTH{1'b1}}) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Array is never reset; writes are held off while rstb is low.
   always_ff @(posedge clk) begin
      if (rstb) begin
         if (clr_en) begin
            mem[clr_cnt_q] <= '0;
         end else if (wr) begin
            for (int k = 0; k < WMASK_WIDTH; k++) begin
               if (bus.wmask[k])
                  mem[bus.addr][k*LANE +: LANE] <= bus.din[k*LANE +: LANE];
            end
         end
      end
   end

   sram22_rd_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
   ) u_rd_pipe (
      .clk     (clk),
      .rstb    (rstb),
      .rd_i    (rd),
      .rdata_i (mem[bus.addr]),
      .dout_o  (bus.dout),
      .valid_o (bus.dout_valid),
      .sae_o   (bus.sae_int)
   );

endmodule

// File: tb/tb_sram22_sp_model.sv
// Directed bench: 64b/lat1/auto-clear instance and 32b/lat2/manual-clear instance.
module tb_sram22_sp_model;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstb0, rstb1;
   int   vec  = 0;
   int   errs = 0;

   sram22_sp_model_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .WMASK_WIDTH(2)) b0 ();
   sram22_sp_model_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WMASK_WIDTH(4)) b1 ();

   sram22_sp_model #(
      .DATA_WIDTH(64), .ADDR_WIDTH(10), .WMASK_WIDTH(2),
      .READ_LATENCY(1), .CLEAR_ON_RESET(1'b1)
   ) u0 (.clk(clk), .rstb(rstb0), .bus(b0));

   sram22_sp_model #(
      .DATA_WIDTH(32), .ADDR_WIDTH(10), .WMASK_WIDTH(4),
      .READ_LATENCY(2), .CLEAR_ON_RESET(1'b0)
   ) u1 (.clk(clk), .rstb(rstb1), .bus(b1));

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wr0(input logic [9:0] a, input logic [63:0] d,
                      input logic [1:0] m);
      b0.req_valid = 1'b1; b0.we = 1'b1;
      b0.addr = a; b0.din = d; b0.wmask = m;
      step();
      b0.req_valid = 1'b0; b0.we = 1'b0;
      chk("wr0_no_dv", 64'(b0.dout_valid), 64'd0);
   endtask

   task automatic rd0(input string tag, input logic [9:0] a,
                      input logic [63:0] exp);
      b0.req_valid = 1'b1; b0.we = 1'b0; b0.addr = a;
      step();
      b0.req_valid = 1'b0;
      chk({tag, "_sae"}, 64'(b0.sae_int), 64'd1);
      chk({tag, "_dv"}, 64'(b0.dout_valid), 64'd1);
      chk(tag, b0.dout, exp);
   endtask

   task automatic wr1(input logic [9:0] a, input logic [31:0] d,
                      input logic [3:0] m);
      b1.req_valid = 1'b1; b1.we = 1'b1;
      b1.addr = a; b1.din = d; b1.wmask = m;
      step();
      b1.req_valid = 1'b0; b1.we = 1'b0;
   endtask

   task automatic rd1(input string tag, input logic [9:0] a,
                      input logic [31:0] exp);
      b1.req_valid = 1'b1; b1.we = 1'b0; b1.addr = a;
      step();
      b1.req_valid = 1'b0;
      chk({tag, "_sae"}, 64'(b1.sae_int), 64'd1);
      chk({tag, "_dv_early"}, 64'(b1.dout_valid), 64'd0);
      step();
      chk({tag, "_dv"}, 64'(b1.dout_valid), 64'd1);
      chk({tag, "_sae_off"}, 64'(b1.sae_int), 64'd0);
      chk(tag, 64'(b1.dout), 64'(exp));
   endtask

   // Counts cycles until busy drops; flags req_ready seen high while busy.
   task automatic wait0(output int n, output bit bad);
      n = 0; bad = 1'b0;
      while (b0.busy && n < 2000) begin
         if (b0.req_ready) bad = 1'b1;
         if (n == 500) b0.clear_start = 1'b1;
         if (n == 501) b0.clear_start = 1'b0;
         step();
         n++;
      end
   endtask

   task automatic wait1(output int n, output bit bad);
      n = 0; bad = 1'b0;
      while (b1.busy && n < 2000) begin
         if (b1.req_ready) bad = 1'b1;
         step();
         n++;
      end
   endtask

   logic [63:0] v [4];
   int          n;
   bit          bad;

   initial begin
      b0.req_valid = 0; b0.we = 0; b0.wmask = '0; b0.addr = '0;
      b0.din = '0; b0.clear_start = 0;
      b1.req_valid = 0; b1.we = 0; b1.wmask = '0; b1.addr = '0;
      b1.din = '0; b1.clear_start = 0;
      rstb0 = 1'b1; rstb1 = 1'b1;
      #2;
      rstb0 = 1'b0; rstb1 = 1'b0;
      step(); step();

      chk("rst0_busy", 64'(b0.busy), 64'd1);
      chk("rst0_ready", 64'(b0.req_ready), 64'd0);
      chk("rst0_dv", 64'(b0.dout_valid), 64'd0);
      chk("rst0_sae", 64'(b0.sae_int), 64'd0);
      chk("rst0_dout", b0.dout, 64'd0);
      chk("rst1_busy", 64'(b1.busy), 64'd0);
      chk("rst1_ready", 64'(b1.req_ready), 64'd1);

      // Auto-clear sweep after reset release
      rstb0 = 1'b1; rstb1 = 1'b1;
      wait0(n, bad);
      chk("sweep0_cycles", 64'(n), 64'd1024);
      chk("sweep0_ready_low", 64'(bad), 64'd0);
      chk("sweep0_ready_after", 64'(b0.req_ready), 64'd1);
      rd0("clr_rd0", 10'd0, 64'd0);
      rd0("clr_rd1023", 10'd1023, 64'd0);
      rd0("clr_rd512", 10'd512, 64'd0);

      // Lane-masked write, then write/read-next-cycle
      wr0(10'd5, 64'hDEADBEEF_CAFEF00D, 2'b01);
      rd0("mask_rd5", 10'd5, 64'h00000000_CAFEF00D);
      wr0(10'd5, 64'h12345678_9ABCDEF0, 2'b10);
      rd0("mask_rd5b", 10'd5, 64'h12345678_CAFEF00D);
      wr0(10'd7, 64'h11223344_55667788, 2'b11);
      rd0("raw_rd7", 10'd7, 64'h11223344_55667788);
      wr0(10'd7, 64'hFFFFFFFF_FFFFFFFF, 2'b00);
      rd0("nop_rd7", 10'd7, 64'h11223344_55667788);

      // Back-to-back reads stream one per cycle
      v[0] = 64'hA0A0_0000_0000_0001; v[1] = 64'hB1B1_0000_0000_0002;
      v[2] = 64'hC2C2_0000_0000_0003; v[3] = 64'hD3D3_0000_0000_0004;
      for (int i = 0; i < 4; i++) wr0(10'(i), v[i], 2'b11);
      for (int i = 0; i < 4; i++) begin
         b0.req_valid = 1'b1; b0.we = 1'b0; b0.addr = 10'(i);
         step();
         chk("b2b_dv", 64'(b0.dout_valid), 64'd1);
         chk("b2b_sae", 64'(b0.sae_int), 64'd1);
         chk("b2b_data", b0.dout, v[i]);
      end
      b0.req_valid = 1'b0;
      step();
      chk("b2b_dv_end", 64'(b0.dout_valid), 64'd0);
      chk("b2b_sae_end", 64'(b0.sae_int), 64'd0);
      chk("b2b_hold", b0.dout, v[3]);

      // Reset mid-sweep at clr_cnt=300
      wr0(10'd100, 64'h0000_1111_2222_3333, 2'b11);
      wr0(10'd900, 64'h4444_5555_6666_7777, 2'b11);
      b0.clear_start = 1'b1;
      step();
      b0.clear_start = 1'b0;
      chk("clr0_busy", 64'(b0.busy), 64'd1);
      for (int i = 0; i < 300; i++) step();
      rstb0 = 1'b0;
      chk("midrst_busy", 64'(b0.busy), 64'd1);
      chk("midrst_ready", 64'(b0.req_ready), 64'd0);
      step(); step();
      rstb0 = 1'b1;
      wait0(n, bad);
      chk("sweep0b_cycles", 64'(n), 64'd1024);
      chk("sweep0b_ready_low", 64'(bad), 64'd0);
      rd0("resweep_rd100", 10'd100, 64'd0);
      rd0("resweep_rd900", 10'd900, 64'd0);
      rd0("resweep_rd5", 10'd5, 64'd0);

      // Latency 2, byte lanes
      wr1(10'd2, 32'hAABBCCDD, 4'b1111);
      rd1("l2_full", 10'd2, 32'hAABBCCDD);
      wr1(10'd2, 32'h11223344, 4'b0101);
      rd1("l2_m0101", 10'd2, 32'hAA22CC44);
      wr1(10'd2, 32'h55667788, 4'b1010);
      rd1("l2_m1010", 10'd2, 32'h55227744);
      wr1(10'd2, 32'hFFFFFFFF, 4'b0000);
      rd1("l2_m0000", 10'd2, 32'h55227744);
      wr1(10'd1, 32'h12345678, 4'b1111);

      // Reset with a read in flight
      b1.req_valid = 1'b1; b1.we = 1'b0; b1.addr = 10'd1;
      step();
      b1.req_valid = 1'b0;
      rstb1 = 1'b0;
      chk("inflight_dv0", 64'(b1.dout_valid), 64'd0);
      step();
      chk("inflight_dv1", 64'(b1.dout_valid), 64'd0);
      chk("inflight_dout", 64'(b1.dout), 64'd0);
      rstb1 = 1'b1;
      step();
      chk("inflight_dv2", 64'(b1.dout_valid), 64'd0);
      chk("rst1b_busy", 64'(b1.busy), 64'd0);

      // Manual clear on the no-auto-clear instance
      rd1("keep_rd1", 10'd1, 32'h12345678);
      b1.clear_start = 1'b1;
      step();
      b1.clear_start = 1'b0;
      wait1(n, bad);
      chk("sweep1_cycles", 64'(n), 64'd1024);
      chk("sweep1_ready_low", 64'(bad), 64'd0);
      rd1("clr1_rd1", 10'd1, 32'd0);
      rd1("clr1_rd2", 10'd2, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
